mips_ex_alu: RTL and testbench
==============================

// Module: mips_ex_alu
// PURPOSE
//  Execute-stage integer ALU of the 5-stage MIPS pipeline.
//  Takes the two operands and the 6-bit MIPS R-type funct code from the ID/EXE register.
//  Produces a registered 32-bit result plus zero and overflow flags on the next rising clk.
//  Output feeds the EXE/MEM pipeline register and the forwarding network.
// PARAMETERS
//  WIDTH  32  datapath width; all arithmetic rules below are written for WIDTH=32
// PORTS
//  clk                   in   1   pipeline clock; all state updates on posedge
//  rst_n                 in   1   synchronous reset, active-low
//  out_ID_EXE_Op1        in   32  operand A (rs value, or shamt zero-extended for immediate shifts)
//  out_ID_EXE_Op2        in   32  operand B (rt value or sign/zero-extended immediate)
//  out_ID_EXE_Operation  in   6   MIPS funct code selecting the operation
//  ALU_Result            out  32  registered result
//  ALU_Zero              out  1   registered; 1 when ALU_Result==0
//  ALU_Overflow          out  1   registered; signed overflow of add/sub
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-low.
//  Reset: rst_n==0 at posedge -> ALU_Result=0, ALU_Zero=1, ALU_Overflow=0.
//  Latency: exactly 1 cycle. Inputs sampled at posedge N appear on outputs after posedge N.
//   No handshake; a new operation is accepted every cycle.
//  Outputs hold between edges. Reset dominates any operation on the same edge.
//  Let A=Op1, B=Op2, s=A[4:0]. Operations are selected by the funct code:
//   0x20 add   A+B (mod 2^32); Overflow = signed overflow
//   0x21 addu  A+B (mod 2^32); Overflow=0
//   0x22 sub   A-B (mod 2^32); Overflow = signed overflow
//   0x23 subu  A-B (mod 2^32); Overflow=0
//   0x24 and   A&B
//   0x25 or    A|B
//   0x26 xor   A^B
//   0x27 nor   ~(A|B)
//   0x2A slt   {31'b0, $signed(A)<$signed(B)}
//   0x2B sltu  {31'b0, A<B unsigned}
//   0x00 sll   B<<s
//   0x02 srl   B>>s, zero fill
//   0x03 sra   B>>>s, sign fill from B[31]
//   0x04 sllv  same as sll
//   0x06 srlv  same as srl
//   0x07 srav  same as sra
//   other: Result=0, Overflow=0. Unknown codes are never X.
//  Overflow rule for add: A[31]==B[31] && R[31]!=A[31].
//  Overflow rule for sub: A[31]!=B[31] && R[31]!=A[31].
//  On overflow the wrapped result is still written; no trap is raised.
//  Only A[4:0] is used for shifts; A[31:5] is ignored. s=0 passes B unchanged.
//  ALU_Zero is computed from the new result and registered in the same edge as ALU_Result.
//  The block is purely combinational apart from the output register; it has no other state.
// TESTING
//  1. rst_n=0 for 2 edges -> Result=0, Zero=1, Ovf=0. Release rst_n, then apply op 0x20, A=1, B=0xA -> Result=0xB after 1 edge.
//  2. add A=0x7FFFFFFF, B=1 -> Result=0x80000000, Ovf=1.
//     addu with the same operands -> Result=0x80000000, Ovf=0.
//     sub A=5, B=5 -> Result=0, Zero=1.
//  3. slt A=0xFFFFFFFF, B=1 -> 1. sltu with the same operands -> 0.
//     nor A=0, B=0 -> 0xFFFFFFFF.
//  4. sra B=0x80000000, A=4 -> 0xF8000000. srl with the same operands -> 0x08000000.
//     sll B=1, A=0x25 (s=5) -> 0x20.
//  5. Back-to-back ops on consecutive edges: each result appears exactly one edge later.
//     Assert rst_n mid-stream -> outputs go to reset values on that edge.
//     Undefined code 0x3F -> Result=0, Ovf=0.

Source files
------------

// File: rtl/mips_ex_alu.sv
// Execute-stage integer ALU: decodes the MIPS R-type funct code and registers
// the result together with zero and signed-overflow flags one clock later.
module mips_ex_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] out_ID_EXE_Op1,
    input  logic [WIDTH-1:0] out_ID_EXE_Op2,
    input  logic [5:0]       out_ID_EXE_Operation,
    output logic [WIDTH-1:0] ALU_Result,
    output logic             ALU_Zero,
    output logic             ALU_Overflow
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_SRA  = 6'h03,
        FN_SLLV = 6'h04,
        FN_SRLV = 6'h06,
        FN_SRAV = 6'h07,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_e;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt_bit;
    logic             sltu_bit;
    logic [WIDTH-1:0] result_next;
    logic             overflow_next;
    logic             zero_next;

    assign op_a  = out_ID_EXE_Op1;
    assign op_b  = out_ID_EXE_Op2;
    // Only the low bits of A form the shift amount; the rest is ignored.
    assign shamt = op_a[SHW-1:0];

    assign sum      = op_a + op_b;
    assign diff     = op_a - op_b;
    assign add_ovf  = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1]  != op_a[WIDTH-1]);
    assign sub_ovf  = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
    assign slt_bit  = $signed(op_a) < $signed(op_b);
    assign sltu_bit = op_a < op_b;

    always_comb begin
        result_next   = '0;
        overflow_next = 1'b0;
        case (out_ID_EXE_Operation)
            FN_ADD:  begin result_next = sum;  overflow_next = add_ovf; end
            FN_ADDU: result_next = sum;
            FN_SUB:  begin result_next = diff; overflow_next = sub_ovf; end
            FN_SUBU: result_next = diff;
            FN_AND:  result_next = op_a & op_b;
            FN_OR:   result_next = op_a | op_b;
            FN_XOR:  result_next = op_a ^ op_b;
            FN_NOR:  result_next = ~(op_a | op_b);
            FN_SLT:  result_next = {{(WIDTH-1){1'b0}}, slt_bit};
            FN_SLTU: result_next = {{(WIDTH-1){1'b0}}, sltu_bit};
            FN_SLL, FN_SLLV: result_next = op_b << shamt;
            FN_SRL, FN_SRLV: result_next = op_b >> shamt;
            FN_SRA, FN_SRAV: result_next = $unsigned($signed(op_b) >>> shamt);
            default: begin
                result_next   = '0;
                overflow_next = 1'b0;
            end
        endcase
    end

    assign zero_next = (result_next == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ALU_Result   <= '0;
            ALU_Zero     <= 1'b1;
            ALU_Overflow <= 1'b0;
        end else begin
            ALU_Result   <= result_next;
            ALU_Zero     <= zero_next;
            ALU_Overflow <= overflow_next;
        end
    end

endmodule

// File: tb/tb_mips_ex_alu.sv
// Bench for mips_ex_alu: directed vector table, reset/back-to-back sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_mips_ex_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [5:0]  operation;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_overflow;

    int checks = 0;
    int errors = 0;

    mips_ex_alu #(.WIDTH(32)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .out_ID_EXE_Op1       (op1),
        .out_ID_EXE_Op2       (op2),
        .out_ID_EXE_Operation (operation),
        .ALU_Result           (alu_result),
        .ALU_Zero             (alu_zero),
        .ALU_Overflow         (alu_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        o;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] r, input logic z, input logic o);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.r = r; v.z = z; v.o = o;
        return v;
    endfunction

    // Reference model: evaluates each funct code with wide signed/unsigned integer arithmetic.
    task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic z, output logic o);
        longint      sa;
        longint      sb;
        longint      t;
        longint      p2;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] prod;
        int          s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        s  = int'(a % 32);
        p2 = longint'(1) << s;
        r  = 32'd0;
        o  = 1'b0;
        case (op)
            6'h20: begin
                t = sa + sb;
                r = t[31:0];
                o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            6'h21: begin prod = (ua + ub) % 64'h1_0000_0000; r = prod[31:0]; end
            6'h22: begin
                t = sa - sb;
                r = t[31:0];
                o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            6'h23: begin prod = (ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000; r = prod[31:0]; end
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
            6'h2B: r = (ua < ub) ? 32'd1 : 32'd0;
            6'h00, 6'h04: begin prod = ub * 64'(p2); r = prod[31:0]; end
            6'h02, 6'h06: begin prod = ub / 64'(p2); r = prod[31:0]; end
            6'h03, 6'h07: begin
                t = sb / p2;
                if (sb < 0 && (sb % p2) != 0) t = t - 1;
                r = t[31:0];
            end
            default: begin r = 32'd0; o = 1'b0; end
        endcase
        z = (r == 32'd0);
    endtask

    task automatic check(input string name, input logic [31:0] er, input logic ez, input logic eo);
        checks++;
        if (alu_result !== er || alu_zero !== ez || alu_overflow !== eo) begin
            errors++;
            $display("FAIL %s: got r=%08h z=%0b o=%0b, expected r=%08h z=%0b o=%0b",
                     name, alu_result, alu_zero, alu_overflow, er, ez, eo);
        end else begin
            $display("ok   %s: r=%08h z=%0b o=%0b", name, alu_result, alu_zero, alu_overflow);
        end
    endtask

    // One transaction: drive on the falling edge, capture on the rising edge, sample 1 time unit later.
    task automatic apply(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        operation = op;
        op1 = a;
        op2 = b;
        @(posedge clk);
        #1;
    endtask

    logic [5:0] valid_ops [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                   6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [31:0] corner [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1F};

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        logic [31:0] er;
        logic        ez;
        logic        eo;
        logic [5:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs.push_back(mk(6'h20, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1));
        vecs.push_back(mk(6'h21, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b0));
        vecs.push_back(mk(6'h22, 32'h5,         32'h5,         32'h0,         1'b1, 1'b0));
        vecs.push_back(mk(6'h22, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0, 1'b1));
        vecs.push_back(mk(6'h20, 32'h8000_0000, 32'h8000_0000, 32'h0,         1'b1, 1'b1));
        vecs.push_back(mk(6'h21, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0));
        vecs.push_back(mk(6'h23, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1'b0));
        vecs.push_back(mk(6'h2A, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0));
        vecs.push_back(mk(6'h2B, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0));
        vecs.push_back(mk(6'h27, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0));
        vecs.push_back(mk(6'h24, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0));
        vecs.push_back(mk(6'h25, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0, 1'b0));
        vecs.push_back(mk(6'h26, 32'hAAAA_5555, 32'hFFFF_FFFF, 32'h5555_AAAA, 1'b0, 1'b0));
        vecs.push_back(mk(6'h03, 32'h4,         32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0));
        vecs.push_back(mk(6'h02, 32'h4,         32'h8000_0000, 32'h0800_0000, 1'b0, 1'b0));
        vecs.push_back(mk(6'h00, 32'h25,        32'h1,         32'h20,        1'b0, 1'b0));
        vecs.push_back(mk(6'h07, 32'h20,        32'h1234,      32'h1234,      1'b0, 1'b0));
        vecs.push_back(mk(6'h04, 32'h1F,        32'h3,         32'h8000_0000, 1'b0, 1'b0));
        vecs.push_back(mk(6'h03, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0));
        vecs.push_back(mk(6'h06, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1,         1'b0, 1'b0));
        vecs.push_back(mk(6'h3F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0));
        vecs.push_back(mk(6'h01, 32'h7FFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0));

        rst_n     = 1'b0;
        operation = 6'h20;
        op1       = 32'h7FFF_FFFF;
        op2       = 32'h1;

        // Reset held for two edges while an overflowing add is on the inputs.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset", 32'h0, 1'b1, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        apply(6'h20, 32'h1, 32'hA);
        check("first_add", 32'hB, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec[%0d] op=%02h", i, vecs[i].op), vecs[i].r, vecs[i].z, vecs[i].o);
        end

        // Outputs must hold while new inputs wait for the next edge.
        apply(6'h25, 32'h0000_00F0, 32'h0000_000F);
        @(negedge clk);
        operation = 6'h22;
        op1 = 32'h0;
        op2 = 32'h0;
        #2;
        check("hold_between_edges", 32'h0000_00FF, 1'b0, 1'b0);

        // Back-to-back: each result visible exactly one edge after its inputs.
        apply(6'h20, 32'd10, 32'd20);
        check("b2b_0", 32'd30, 1'b0, 1'b0);
        apply(6'h22, 32'd3, 32'd7);
        check("b2b_1", 32'hFFFF_FFFC, 1'b0, 1'b0);
        apply(6'h22, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        check("b2b_2", 32'h8000_0000, 1'b0, 1'b1);

        // Mid-stream reset dominates an active operation, then normal flow resumes.
        @(negedge clk);
        rst_n = 1'b0;
        operation = 6'h20;
        op1 = 32'h7FFF_FFFF;
        op2 = 32'h7FFF_FFFF;
        @(posedge clk);
        #1;
        check("midstream_reset", 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset", 32'hFFFF_FFFE, 1'b0, 1'b1);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) rop = 6'($urandom);
            else rop = valid_ops[$urandom_range(0, 15)];
            ra = pick_operand();
            rb = pick_operand();
            model(rop, ra, rb, er, ez, eo);
            apply(rop, ra, rb);
            check($sformatf("rand[%0d] op=%02h a=%08h b=%08h", n, rop, ra, rb), er, ez, eo);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
